// File: rtl/cpu_run_ctrl_if.sv
// Monitor-side command channel for cpu_run_ctrl: valid/ready request plus done/err response.
interface cpu_run_ctrl_if;
    logic        cmd_valid;
    logic [1:0]  cmd_code;
    logic [15:0] step_cnt;
    logic        cmd_ready;
    logic        cmd_done;
    logic        cmd_err;

    modport master (
        output cmd_valid, cmd_code, step_cnt,
        input  cmd_ready, cmd_done, cmd_err
    );

    modport slave (
        input  cmd_valid, cmd_code, step_cnt,
        output cmd_ready, cmd_done, cmd_err
    );
endinterface

// File: rtl/cpu_run_ctrl.sv
// Run controller: turns monitor start/quit/step commands into cpu_start/quit_cmd pulses.
// Define RUN_CTRL_STEP_EN to build the step down-counter (auto-quit after N unstalled cycles).
module cpu_run_ctrl (
    input  logic          clk,
    input  logic          rst_n,
    cpu_run_ctrl_if.slave bus,
    input  logic          init_calib_complete,
    input  logic          stall,
    input  logic          rst_pipe_wb,
    output logic          cpu_start,
    output logic          quit_cmd,
    output logic          cpu_running,
    output logic [31:0]   run_cycles
);

    localparam logic [1:0] CmdNop   = 2'b00;
    localparam logic [1:0] CmdStart = 2'b01;
    localparam logic [1:0] CmdQuit  = 2'b10;
    localparam logic [1:0] CmdStep  = 2'b11;

`ifdef RUN_CTRL_STEP_EN
    localparam bit StepEn = 1'b1;
`else
    localparam bit StepEn = 1'b0;
`endif

    typedef enum logic [2:0] {
        StIdle, StWaitCal, StStart, StSyncS, StRun, StQuit, StSyncQ
    } state_e;

    state_e      state_q, state_d;
    logic        accept, launch_ok, launch, auto_quit;
    logic        done_d, err_d;
    logic        cpu_start_q, quit_cmd_q, cmd_done_q, cmd_err_q;
    logic [31:0] run_cycles_q;

    assign bus.cmd_ready = (state_q == StIdle) || (state_q == StWaitCal) || (state_q == StRun);
    assign accept        = bus.cmd_valid & bus.cmd_ready;
    // A zero-length step is never launched; without the step build no step launches at all.
    assign launch_ok     = (bus.cmd_code == CmdStart) |
                           ((bus.cmd_code == CmdStep) & StepEn & (bus.step_cnt != 16'd0));
    assign launch        = accept & (state_q == StIdle) & launch_ok;

`ifdef RUN_CTRL_STEP_EN
    logic [15:0] step_q;
    logic        step_active_q;

    assign auto_quit = step_active_q & ~stall & (step_q == 16'd1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            step_q        <= 16'd0;
            step_active_q <= 1'b0;
        end else if (launch) begin
            step_q        <= bus.step_cnt;
            step_active_q <= (bus.cmd_code == CmdStep);
        end else if ((state_q == StRun) && step_active_q && !stall && (step_q != 16'd0)) begin
            step_q <= step_q - 16'd1;
        end
    end
`else
    assign auto_quit = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            StIdle: begin
                if (accept) begin
                    if (launch_ok) begin
                        state_d = init_calib_complete ? StStart : StWaitCal;
                    end else begin
                        done_d = 1'b1;
                        err_d  = (bus.cmd_code == CmdStep);
                    end
                end
            end
            StWaitCal: begin
                if (accept && (bus.cmd_code == CmdQuit)) begin
                    state_d = StIdle;
                    done_d  = 1'b1;
                end else begin
                    if (accept) begin
                        done_d = 1'b1;
                        err_d  = (bus.cmd_code != CmdNop);
                    end
                    if (init_calib_complete) state_d = StStart;
                end
            end
            StStart: state_d = StSyncS;
            StSyncS: begin
                if (rst_pipe_wb) begin
                    state_d = StRun;
                    done_d  = 1'b1;
                end
            end
            StRun: begin
                // Losing calibration abandons the run silently.
                if (!init_calib_complete) begin
                    state_d = StIdle;
                end else if ((accept && (bus.cmd_code == CmdQuit)) || auto_quit) begin
                    state_d = StQuit;
                end else if (accept) begin
                    done_d = 1'b1;
                    err_d  = (bus.cmd_code != CmdNop);
                end
            end
            StQuit: state_d = StSyncQ;
            StSyncQ: begin
                if (rst_pipe_wb) begin
                    state_d = StIdle;
                    done_d  = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            cpu_start_q  <= 1'b0;
            quit_cmd_q   <= 1'b0;
            cmd_done_q   <= 1'b0;
            cmd_err_q    <= 1'b0;
            run_cycles_q <= 32'd0;
        end else begin
            state_q     <= state_d;
            cpu_start_q <= (state_d == StStart);
            quit_cmd_q  <= (state_d == StQuit);
            cmd_done_q  <= done_d;
            cmd_err_q   <= err_d;
            if (launch) begin
                run_cycles_q <= 32'd0;
            end else if ((state_q == StRun) && !stall) begin
                run_cycles_q <= run_cycles_q + 32'd1;
            end
        end
    end

    assign cpu_start    = cpu_start_q;
    assign quit_cmd     = quit_cmd_q;
    assign cpu_running  = (state_q == StRun);
    assign run_cycles   = run_cycles_q;
    assign bus.cmd_done = cmd_done_q;
    assign bus.cmd_err  = cmd_err_q;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Self-checking bench for cpu_run_ctrl with randomized stall/sync timing and a counting model.
module tb_cpu_run_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        init_calib_complete, stall, rst_pipe_wb;
    logic        cpu_start, quit_cmd, cpu_running;
    logic [31:0] run_cycles;

    int total = 0;
    int bad = 0;
    int n_start = 0;
    int n_quit = 0;
    int exp_starts = 0;
    int exp_quits = 0;
    logic both_seen = 1'b0;

    cpu_run_ctrl_if bus ();

    cpu_run_ctrl dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .bus                 (bus),
        .init_calib_complete (init_calib_complete),
        .stall               (stall),
        .rst_pipe_wb         (rst_pipe_wb),
        .cpu_start           (cpu_start),
        .quit_cmd            (quit_cmd),
        .cpu_running         (cpu_running),
        .run_cycles          (run_cycles)
    );

    always #5 clk = ~clk;

    // Pulse census, sampled mid-cycle.
    always @(negedge clk) begin
        if (cpu_start) n_start <= n_start + 1;
        if (quit_cmd) n_quit <= n_quit + 1;
        if (cpu_start && quit_cmd) both_seen <= 1'b1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [1:0] code, input logic [15:0] cnt);
        bus.cmd_valid = 1'b1;
        bus.cmd_code  = code;
        bus.step_cnt  = cnt;
        tick();
        bus.cmd_valid = 1'b0;
        bus.cmd_code  = 2'b00;
    endtask

    // Start and deliver the reset wave dly edges after the accept edge.
    task automatic go_run(input int dly);
        send(2'b01, 16'd0);
        repeat (dly) tick();
        rst_pipe_wb = 1'b1;
        tick();
        rst_pipe_wb = 1'b0;
    endtask

    task automatic go_idle(input int dly);
        stall = 1'b1;
        send(2'b10, 16'd0);
        repeat (dly) tick();
        rst_pipe_wb = 1'b1;
        tick();
        rst_pipe_wb = 1'b0;
        stall = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        total++;
        if ({bus.cmd_ready, bus.cmd_done, bus.cmd_err, cpu_start, quit_cmd, cpu_running} !== 6'b100000)
        begin
            bad++;
            $display("FAIL reset_flags: got %b want 100000",
                     {bus.cmd_ready, bus.cmd_done, bus.cmd_err, cpu_start, quit_cmd, cpu_running});
        end
        total++;
        if (run_cycles !== 32'd0) begin
            bad++;
            $display("FAIL reset_run_cycles: got %0d want 0", run_cycles);
        end
        #10 rst_n = 1'b1;
        tick();
        total++;
        if (bus.cmd_ready !== 1'b1 || cpu_running !== 1'b0) begin
            bad++;
            $display("FAIL post_reset_idle: ready=%b running=%b want 1 0", bus.cmd_ready, cpu_running);
        end
    endtask

    task automatic test_start();
        init_calib_complete = 1'b1;
        stall = 1'b0;
        send(2'b01, 16'd0);
        exp_starts++;
        total++;
        if (cpu_start !== 1'b1 || bus.cmd_ready !== 1'b0) begin
            bad++;
            $display("FAIL start_pulse: start=%b ready=%b want 1 0", cpu_start, bus.cmd_ready);
        end
        tick();
        total++;
        if (cpu_start !== 1'b0) begin
            bad++;
            $display("FAIL start_width: got %b want 0", cpu_start);
        end
        repeat (4) tick();
        total++;
        if (cpu_running !== 1'b0 || bus.cmd_done !== 1'b0) begin
            bad++;
            $display("FAIL sync_wait: running=%b done=%b want 0 0", cpu_running, bus.cmd_done);
        end
        rst_pipe_wb = 1'b1;
        tick();
        rst_pipe_wb = 1'b0;
        total++;
        if ({cpu_running, bus.cmd_done, bus.cmd_err, bus.cmd_ready} !== 4'b1101) begin
            bad++;
            $display("FAIL run_entry: got %b want 1101",
                     {cpu_running, bus.cmd_done, bus.cmd_err, bus.cmd_ready});
        end
        repeat (20) tick();
        total++;
        if (run_cycles !== 32'd20) begin
            bad++;
            $display("FAIL run_cycles_20: got %0d want 20", run_cycles);
        end
        go_idle(5);
        exp_quits++;
    endtask

    task automatic test_wait_cal();
        int k;
        int s0;
        init_calib_complete = 1'b0;
        s0 = n_start;
        send(2'b01, 16'd0);
        k = $urandom_range(2, 6);
        repeat (k) tick();
        total++;
        if (cpu_start !== 1'b0 || bus.cmd_ready !== 1'b1 || n_start != s0) begin
            bad++;
            $display("FAIL wait_cal_hold: start=%b ready=%b pulses=%0d want 0 1 0",
                     cpu_start, bus.cmd_ready, n_start - s0);
        end
        init_calib_complete = 1'b1;
        tick();
        exp_starts++;
        total++;
        if (cpu_start !== 1'b1) begin
            bad++;
            $display("FAIL wait_cal_release: got %b want 1", cpu_start);
        end
        repeat (5) tick();
        rst_pipe_wb = 1'b1;
        tick();
        rst_pipe_wb = 1'b0;
        total++;
        if (cpu_running !== 1'b1 || n_start - s0 != 1) begin
            bad++;
            $display("FAIL wait_cal_run: running=%b pulses=%0d want 1 1", cpu_running, n_start - s0);
        end
        go_idle(5);
        exp_quits++;
        // Second run abandoned with quit while still waiting on calibration.
        init_calib_complete = 1'b0;
        s0 = n_start;
        send(2'b01, 16'd0);
        tick();
        send(2'b10, 16'd0);
        total++;
        if ({bus.cmd_done, bus.cmd_err, bus.cmd_ready, cpu_running} !== 4'b1010) begin
            bad++;
            $display("FAIL wait_cal_quit: got %b want 1010",
                     {bus.cmd_done, bus.cmd_err, bus.cmd_ready, cpu_running});
        end
        init_calib_complete = 1'b1;
        repeat (3) tick();
        total++;
        if (n_start != s0) begin
            bad++;
            $display("FAIL wait_cal_quit_nostart: pulses=%0d want 0", n_start - s0);
        end
    endtask

    task automatic test_quit_hold();
        int left_slots;
        int left_stalls;
        int z;
        go_run(5);
        exp_starts++;
        left_slots = 12;
        left_stalls = 5;
        z = 0;
        repeat (12) begin
            stall = ($urandom_range(0, left_slots - 1) < left_stalls);
            if (stall) left_stalls--;
            else z++;
            left_slots--;
            tick();
        end
        total++;
        if (run_cycles !== 32'(z) || z != 7) begin
            bad++;
            $display("FAIL stall_count: got %0d want 7", run_cycles);
        end
        stall = 1'b1;
        send(2'b10, 16'd0);
        exp_quits++;
        total++;
        if (quit_cmd !== 1'b1 || cpu_start !== 1'b0) begin
            bad++;
            $display("FAIL quit_pulse: quit=%b start=%b want 1 0", quit_cmd, cpu_start);
        end
        tick();
        total++;
        if (quit_cmd !== 1'b0) begin
            bad++;
            $display("FAIL quit_width: got %b want 0", quit_cmd);
        end
        repeat (4) tick();
        rst_pipe_wb = 1'b1;
        tick();
        rst_pipe_wb = 1'b0;
        stall = 1'b0;
        total++;
        if ({bus.cmd_done, bus.cmd_err, cpu_running, bus.cmd_ready} !== 4'b1001) begin
            bad++;
            $display("FAIL quit_done: got %b want 1001",
                     {bus.cmd_done, bus.cmd_err, cpu_running, bus.cmd_ready});
        end
        repeat (5) tick();
        total++;
        if (run_cycles !== 32'd7) begin
            bad++;
            $display("FAIL run_cycles_hold: got %0d want 7", run_cycles);
        end
    endtask

    task automatic test_reject();
        int q0;
        int s0;
        go_run(5);
        exp_starts++;
        stall = 1'b1;
        send(2'b01, 16'd0);
        total++;
        if ({bus.cmd_done, bus.cmd_err, cpu_running} !== 3'b111) begin
            bad++;
            $display("FAIL run_start_reject: got %b want 111", {bus.cmd_done, bus.cmd_err, cpu_running});
        end
        send(2'b00, 16'd0);
        total++;
        if ({bus.cmd_done, bus.cmd_err, cpu_running} !== 3'b101) begin
            bad++;
            $display("FAIL run_nop: got %b want 101", {bus.cmd_done, bus.cmd_err, cpu_running});
        end
        send(2'b11, 16'd9);
        total++;
        if ({bus.cmd_done, bus.cmd_err, cpu_running} !== 3'b111) begin
            bad++;
            $display("FAIL run_step_reject: got %b want 111", {bus.cmd_done, bus.cmd_err, cpu_running});
        end
        go_idle(5);
        exp_quits++;
        q0 = n_quit;
        s0 = n_start;
        send(2'b10, 16'd0);
        repeat (1) begin
            total++;
            if ({bus.cmd_done, bus.cmd_err, bus.cmd_ready} !== 3'b101) begin
                bad++;
                $display("FAIL idle_quit: got %b want 101", {bus.cmd_done, bus.cmd_err, bus.cmd_ready});
            end
        end
        send(2'b11, 16'd0);
        total++;
        if ({bus.cmd_done, bus.cmd_err, bus.cmd_ready} !== 3'b111) begin
            bad++;
            $display("FAIL step_zero: got %b want 111", {bus.cmd_done, bus.cmd_err, bus.cmd_ready});
        end
`ifndef RUN_CTRL_STEP_EN
        send(2'b11, 16'd5);
        total++;
        if ({bus.cmd_done, bus.cmd_err, bus.cmd_ready} !== 3'b111) begin
            bad++;
            $display("FAIL step_disabled: got %b want 111", {bus.cmd_done, bus.cmd_err, bus.cmd_ready});
        end
`endif
        repeat (3) tick();
        total++;
        if (n_quit != q0 || n_start != s0 || bus.cmd_done !== 1'b0) begin
            bad++;
            $display("FAIL idle_no_pulse: quits=%0d starts=%0d done=%b want 0 0 0",
                     n_quit - q0, n_start - s0, bus.cmd_done);
        end
    endtask

    task automatic test_calib_drop();
        go_run(5);
        exp_starts++;
        repeat (3) tick();
        init_calib_complete = 1'b0;
        tick();
        total++;
        if ({cpu_running, bus.cmd_ready, bus.cmd_done, quit_cmd} !== 4'b0100) begin
            bad++;
            $display("FAIL calib_drop: got %b want 0100",
                     {cpu_running, bus.cmd_ready, bus.cmd_done, quit_cmd});
        end
        init_calib_complete = 1'b1;
        repeat (2) tick();
    endtask

    task automatic test_reset_mid();
        send(2'b01, 16'd0);
        exp_starts++;
        tick();
        #2 rst_n = 1'b0;
        #1;
        total++;
        if ({bus.cmd_ready, bus.cmd_done, bus.cmd_err, cpu_start, quit_cmd, cpu_running} !== 6'b100000
            || run_cycles !== 32'd0) begin
            bad++;
            $display("FAIL reset_mid: flags=%b cycles=%0d want 100000 0",
                     {bus.cmd_ready, bus.cmd_done, bus.cmd_err, cpu_start, quit_cmd, cpu_running},
                     run_cycles);
        end
        #2 rst_n = 1'b1;
        rst_pipe_wb = 1'b1;
        tick();
        rst_pipe_wb = 1'b0;
        total++;
        if (cpu_running !== 1'b0 || bus.cmd_done !== 1'b0 || bus.cmd_ready !== 1'b1) begin
            bad++;
            $display("FAIL wave_ignored: running=%b done=%b ready=%b want 0 0 1",
                     cpu_running, bus.cmd_done, bus.cmd_ready);
        end
    endtask

`ifdef RUN_CTRL_STEP_EN
    task automatic test_step();
        int c;
        int z;
        logic early;
        c = $urandom_range(2, 6);
        send(2'b11, 16'(c));
        exp_starts++;
        repeat (5) tick();
        rst_pipe_wb = 1'b1;
        tick();
        rst_pipe_wb = 1'b0;
        total++;
        if (cpu_running !== 1'b1 || bus.cmd_done !== 1'b1) begin
            bad++;
            $display("FAIL step_run: running=%b done=%b want 1 1", cpu_running, bus.cmd_done);
        end
        z = 0;
        early = 1'b0;
        for (int i = 0; i < 40 && z < c; i++) begin
            stall = i[0];
            tick();
            if (!stall) z++;
            if (z < c && quit_cmd) early = 1'b1;
        end
        stall = 1'b0;
        exp_quits++;
        total++;
        if (z != c || early || quit_cmd !== 1'b1 || run_cycles !== 32'(c)) begin
            bad++;
            $display("FAIL step_auto_quit: quit=%b early=%b cycles=%0d want 1 0 %0d",
                     quit_cmd, early, run_cycles, c);
        end
        repeat (5) tick();
        rst_pipe_wb = 1'b1;
        tick();
        rst_pipe_wb = 1'b0;
        total++;
        if ({bus.cmd_done, bus.cmd_err, cpu_running} !== 3'b100) begin
            bad++;
            $display("FAIL step_done: got %b want 100", {bus.cmd_done, bus.cmd_err, cpu_running});
        end
    endtask
`endif

    task automatic test_back_to_back();
        int n;
        int z;
        for (int it = 0; it < 6; it++) begin
            go_run($urandom_range(1, 6));
            exp_starts++;
            total++;
            if (cpu_running !== 1'b1 || bus.cmd_done !== 1'b1) begin
                bad++;
                $display("FAIL b2b_run[%0d]: running=%b done=%b want 1 1", it, cpu_running, bus.cmd_done);
            end
            n = $urandom_range(3, 25);
            z = 0;
            repeat (n) begin
                stall = $urandom_range(0, 1);
                tick();
                if (!stall) z++;
            end
            go_idle($urandom_range(1, 6));
            exp_quits++;
            total++;
            if (bus.cmd_done !== 1'b1 || cpu_running !== 1'b0 || run_cycles !== 32'(z)) begin
                bad++;
                $display("FAIL b2b_quit[%0d]: done=%b running=%b cycles=%0d want 1 0 %0d",
                         it, bus.cmd_done, cpu_running, run_cycles, z);
            end
        end
    endtask

    task automatic test_pulse_census();
        tick();
        total++;
        if (both_seen !== 1'b0 || n_start != exp_starts || n_quit != exp_quits) begin
            bad++;
            $display("FAIL pulse_census: both=%b starts=%0d/%0d quits=%0d/%0d",
                     both_seen, n_start, exp_starts, n_quit, exp_quits);
        end
    endtask

    initial begin
        bus.cmd_valid = 1'b0;
        bus.cmd_code = 2'b00;
        bus.step_cnt = 16'd0;
        init_calib_complete = 1'b1;
        stall = 1'b0;
        rst_pipe_wb = 1'b0;
        test_reset();
        test_start();
        test_wait_cal();
        test_quit_hold();
        test_reject();
        test_calib_drop();
        test_reset_mid();
`ifdef RUN_CTRL_STEP_EN
        test_step();
`endif
        test_back_to_back();
        test_pulse_census();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cpu_run_ctrl.md
# cpu_run_ctrl

Command-side run controller that drives the CPU status block's `cpu_start` / `quit_cmd` inputs. It accepts start/quit/step commands from the debug monitor over a valid/ready handshake and holds a start until DRAM calibration completes. It issues single-cycle start/quit pulses and waits for the pipeline-reset wave (`rst_pipe_wb`) to finish before acknowledging. It also counts non-stalled run cycles for the monitor.

## Interface
- No parameters.
- `clk` in 1: system clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `cmd_valid` in 1: monitor command valid.
- `cmd_code` in 2: 00 nop, 01 start, 10 quit, 11 step.
- `step_cnt` in 16: step length in non-stalled cycles; sampled at accept.
- `cmd_ready` out 1: command accepted when `cmd_valid & cmd_ready`.
- `init_calib_complete` in 1: DRAM calibration done.
- `stall` in 1: CPU stall from the status block.
- `rst_pipe_wb` in 1: last stage of the pipeline-reset wave.
- `cpu_start` out 1: registered start pulse, 1 cycle.
- `quit_cmd` out 1: registered quit pulse, 1 cycle.
- `cpu_running` out 1: high in RUN only.
- `cmd_done` out 1: registered 1-cycle completion pulse.
- `cmd_err` out 1: valid with `cmd_done`; command rejected.
- `run_cycles` out 32: non-stalled cycle count since the last start.

## Operation
- States are IDLE, WAIT_CAL, START, SYNC_S, RUN, QUIT, SYNC_Q.
- `cmd_ready` = 1 in IDLE, WAIT_CAL and RUN; 0 elsewhere.
- **IDLE**
  - start or step → START if `init_calib_complete`, else WAIT_CAL.
  - quit → `cmd_done` next cycle, no `quit_cmd`, stay in IDLE.
  - nop → `cmd_done` only.
- **WAIT_CAL**
  - → START on the first cycle `init_calib_complete`=1.
  - quit accepted here → IDLE with `cmd_done`; no pulses issued.
- **START**: `cpu_start`=1 for exactly one cycle → SYNC_S.
- **SYNC_S**: wait for `rst_pipe_wb`=1 → RUN; `cmd_done`=1 on the first RUN cycle.
- **RUN**
  - `run_cycles` += 1 on each cycle with `stall`=0; wraps 0xFFFFFFFF→0.
  - quit → QUIT.
  - start/step → `cmd_done` + `cmd_err`; state unchanged.
  - `init_calib_complete` falling → IDLE immediately, no pulses, no `cmd_done`.
- **QUIT**: `quit_cmd`=1 for one cycle → SYNC_Q.
- **SYNC_Q**: wait for `rst_pipe_wb`=1 → IDLE; `cmd_done` on the first IDLE cycle.
- `run_cycles` clears to 0 on acceptance of a start or step; it holds its value otherwise, including after quit.
- A step with `step_cnt`=0 is rejected (`cmd_done` + `cmd_err`) and leaves the state unchanged.
- `rst_pipe_wb` is ignored outside SYNC_S/SYNC_Q.
- A quit accepted in the same cycle an auto-step-quit triggers is treated as one quit with one `cmd_done`.

## Timing
- Reset values: all outputs 0 except `cmd_ready`=1 (IDLE).
- Accept at edge A (calibrated):
  - `cpu_start` high during A+1.
  - `rst_pipe_wb` expected at A+6 (five-stage reset wave).
  - RUN, `cpu_running` and `cmd_done` at A+7.
- Quit accepted at edge Q: `quit_cmd` at Q+1, `rst_pipe_wb` at Q+6, IDLE and `cmd_done` at Q+7.
- Rejections and IDLE quit/nop: `cmd_done`(+`cmd_err`) 1 cycle after accept.
- `cpu_start` and `quit_cmd` are never high together.
- At most one pulse of each per command.
- Asserting `rst_n` mid-operation returns the block to IDLE within the same cycle, with all outputs at reset values; no quit is issued.

## Configuration
- `RUN_CTRL_STEP_EN` defined:
  - Step loads a 16-bit down-counter from `step_cnt`, then starts as for start.
  - In RUN the counter decrements on each cycle with `stall`=0.
  - When it reaches 0 the block enters QUIT automatically; `cmd_done` follows at the end of SYNC_Q.
  - A plain start leaves the counter inactive.
- `RUN_CTRL_STEP_EN` undefined:
  - cmd 11 is rejected with `cmd_err` in every state.
  - No counter logic is built.

## Test plan
- Calibrated start at edge 10 → `cpu_start` at 11; `rst_pipe_wb` driven at 16; `cpu_running`/`cmd_done` at 17; then 20 unstalled cycles → `run_cycles`=20.
- Start with calib low; calib rises at cycle 50 → `cpu_start` at 51, exactly one pulse; quit during WAIT_CAL on a second run → `cmd_done`, no `cpu_start`.
- RUN, stall high 5 of 12 cycles → `run_cycles`=7; quit → `quit_cmd` 1 cycle later; `cmd_done` 6 cycles after the pulse; `run_cycles` holds 7.
- Start in RUN → `cmd_done`+`cmd_err`, `cpu_running` stays 1; quit in IDLE → `cmd_done`, `quit_cmd` stays 0.
- STEP_EN: step `step_cnt`=4, stall every other cycle → auto `quit_cmd` after 4 unstalled cycles, `run_cycles`=4; `step_cnt`=0 → `cmd_err`.
- `init_calib_complete` drops in RUN → IDLE next cycle; `rst_n` low in SYNC_S → all outputs reset, `cmd_ready`=1.
